// File: rtl/mano_seq_ctrl_if.sv
// Mano sequence-controller signal bundle between control logic and the bus decoder.
// Interrupt signals exist only when MANO_INT_EN is defined.
interface mano_seq_ctrl_if #(
  parameter int SC_W = 3,
  parameter int IR_W = 16
) ();
  logic                 start;
  logic                 sc_clr;
  logic [IR_W-1:0]      bus_in;
  logic [SC_W-1:0]      t;
  logic [2**SC_W-1:0]   t_dec;
  logic [IR_W-1:0]      ir_out;
  logic [7:0]           d;
  logic                 i_bit;
  logic                 running;
  logic                 rr_exec;
  logic                 seq_err;
`ifdef MANO_INT_EN
  logic                 ien;
  logic                 fgi;
  logic                 fgo;
  logic                 int_cycle;
`endif

  modport master (
    output start, sc_clr, bus_in,
`ifdef MANO_INT_EN
    output ien, fgi, fgo,
    input  int_cycle,
`endif
    input  t, t_dec, ir_out, d,
    input  i_bit, running, rr_exec, seq_err
  );

  modport slave (
    input  start, sc_clr, bus_in,
`ifdef MANO_INT_EN
    input  ien, fgi, fgo,
    output int_cycle,
`endif
    output t, t_dec, ir_out, d,
    output i_bit, running, rr_exec, seq_err
  );
endinterface

// File: rtl/mano_seq_ctrl.sv
// Mano basic-computer timing controller: SC, IR, I and S flip-flops.
// Define MANO_INT_EN to add the R flip-flop and interrupt cycle.
module mano_seq_ctrl #(
  parameter int              SC_W     = 3,
  parameter int              IR_W     = 16,
  parameter logic [IR_W-1:0] HLT_CODE = 16'h7001
) (
  input logic              clk,
  input logic              rst,
  mano_seq_ctrl_if.slave   io
);
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T7 = '1;
  localparam int TD_W = 2**SC_W;

  logic            s_q, s_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            i_q, i_d;
  logic            serr_q, serr_d;
  logic            hlt;
  logic            int_cyc;
  logic [7:0]      d_w;

  assign hlt = s_q && (sc_q == T3) && (ir_q == HLT_CODE);

`ifdef MANO_INT_EN
  logic r_q, r_d;
  logic r_set;

  // R stays high through T4..T7 but only T0..T2 are the interrupt cycle
  assign int_cyc = s_q && r_q && (sc_q <= T2);
  assign r_set   = s_q && (sc_q > T2) && io.ien && (io.fgi || io.fgo);

  always_comb begin
    r_d = r_q;
    if (r_set)
      r_d = 1'b1;
    if (hlt || (int_cyc && sc_q == T2))
      r_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= r_d;
  end

  assign io.int_cycle = int_cyc;
`else
  assign int_cyc = 1'b0;
`endif

  always_comb begin
    s_d    = s_q;
    sc_d   = sc_q;
    ir_d   = ir_q;
    i_d    = i_q;
    serr_d = 1'b0;
    if (!s_q) begin
      sc_d = '0;
      if (io.start)
        s_d = 1'b1;
    end else begin
      if (hlt) begin
        s_d  = 1'b0;
        sc_d = '0;
      end else if (int_cyc && sc_q == T2) begin
        sc_d = '0;
      end else if (io.sc_clr && !int_cyc) begin
        sc_d = '0;
      end else begin
        sc_d   = sc_q + T1;
        serr_d = (sc_q == T7);
      end
      if (sc_q == T1 && !int_cyc)
        ir_d = io.bus_in;
      if (sc_q == T2 && !int_cyc)
        i_d = ir_q[IR_W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 1'b0;
      sc_q   <= '0;
      ir_q   <= '0;
      i_q    <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      sc_q   <= sc_d;
      ir_q   <= ir_d;
      i_q    <= i_d;
      serr_q <= serr_d;
    end
  end

  assign d_w        = 8'b1 << ir_q[IR_W-2 -: 3];
  assign io.t       = sc_q;
  assign io.t_dec   = s_q ? (TD_W'(1) << sc_q) : '0;
  assign io.ir_out  = ir_q;
  assign io.d       = d_w;
  assign io.i_bit   = i_q;
  assign io.running = s_q;
  assign io.rr_exec = s_q && d_w[7] && !i_q && (sc_q == T3);
  assign io.seq_err = serr_q;
endmodule

// File: tb/tb_mano_seq_ctrl.sv
// Scoreboard bench for mano_seq_ctrl: stimulus pushes expected state,
// a negedge monitor pops and compares.
module tb_mano_seq_ctrl;
  logic clk = 1'b0;
  logic rst;

  mano_seq_ctrl_if ifc ();

  mano_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  t;
    logic        run;
    logic [15:0] ir;
    logic        i;
    logic        rr;
    logic        se;
    logic        ic;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string nm, input logic [2:0] t,
                    input logic run, input logic [15:0] ir,
                    input logic i, input logic rr,
                    input logic se, input logic ic);
    exp_t e;
    e.name = nm; e.t = t; e.run = run; e.ir = ir;
    e.i = i; e.rr = rr; e.se = se; e.ic = ic;
    sb.push_back(e);
  endtask

  initial begin
    exp_t        e;
    logic [39:0] got, want;
    logic [7:0]  td, dd;
    logic        icg, icw;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        td = e.run ? (8'b1 << e.t) : 8'h00;
        dd = 8'b1 << e.ir[14:12];
`ifdef MANO_INT_EN
        icg = ifc.int_cycle;
        icw = e.ic;
`else
        icg = 1'b0;
        icw = 1'b0;
`endif
        got  = {ifc.t, ifc.running, ifc.t_dec, ifc.ir_out, ifc.d,
                ifc.i_bit, ifc.rr_exec, ifc.seq_err, icg};
        want = {e.t, e.run, td, e.ir, dd, e.i, e.rr, e.se, icw};
        n_tot++;
        if (got === want)
          n_pass++;
        else
          $display("FAIL %s: got %h want %h", e.name, got, want);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.sc_clr = 1'b0;
    ifc.bus_in = 16'h0;
`ifdef MANO_INT_EN
    ifc.ien = 1'b0;
    ifc.fgi = 1'b0;
    ifc.fgo = 1'b0;
`endif
    repeat (2) cyc();
    rst = 1'b0;
    ex("reset", 0, 0, 16'h0, 0, 0, 0, 0);
    ifc.start = 1'b1;
    cyc(); ex("start", 0, 1, 16'h0, 0, 0, 0, 0);
    ifc.start = 1'b0;
    ifc.bus_in = 16'h2123;
    cyc(); ex("t1", 1, 1, 16'h0, 0, 0, 0, 0);
    cyc(); ex("ir_load", 2, 1, 16'h2123, 0, 0, 0, 0);
    cyc(); ex("t3", 3, 1, 16'h2123, 0, 0, 0, 0);
    for (int k = 4; k < 8; k++) begin
      cyc(); ex("count", 3'(k), 1, 16'h2123, 0, 0, 0, 0);
    end
    cyc(); ex("wrap", 0, 1, 16'h2123, 0, 0, 1, 0);
    cyc(); ex("wrap_once", 1, 1, 16'h2123, 0, 0, 0, 0);
    ifc.bus_in = 16'h7001;
    cyc(); ex("hlt_load", 2, 1, 16'h7001, 0, 0, 0, 0);
    cyc(); ex("rr_exec", 3, 1, 16'h7001, 0, 1, 0, 0);
    cyc(); ex("halt", 0, 0, 16'h7001, 0, 0, 0, 0);
    cyc(); ex("stay_halt", 0, 0, 16'h7001, 0, 0, 0, 0);
    ifc.start = 1'b1;
    ifc.sc_clr = 1'b1;
    cyc(); ex("restart", 0, 1, 16'h7001, 0, 0, 0, 0);
    ifc.start = 1'b0;
    ifc.sc_clr = 1'b0;
    ifc.bus_in = 16'h9123;
    cyc(); ex("t1b", 1, 1, 16'h7001, 0, 0, 0, 0);
    cyc(); ex("ir_load_b", 2, 1, 16'h9123, 0, 0, 0, 0);
    cyc(); ex("i_set", 3, 1, 16'h9123, 1, 0, 0, 0);
    cyc(); ex("t4b", 4, 1, 16'h9123, 1, 0, 0, 0);
    ifc.sc_clr = 1'b1;
    ifc.start = 1'b1;
    cyc(); ex("sc_clr", 0, 1, 16'h9123, 1, 0, 0, 0);
    ifc.sc_clr = 1'b0;
    ifc.start = 1'b0;
    ifc.bus_in = 16'h1000;
    cyc(); ex("t1c", 1, 1, 16'h9123, 1, 0, 0, 0);
    cyc(); ex("ir_load_c", 2, 1, 16'h1000, 1, 0, 0, 0);
    cyc(); ex("i_clr", 3, 1, 16'h1000, 0, 0, 0, 0);
    cyc(); ex("t4c", 4, 1, 16'h1000, 0, 0, 0, 0);
    cyc();
    rst = 1'b1;
    ex("rst_async", 0, 0, 16'h0, 0, 0, 0, 0);
    cyc(); ex("rst_hold", 0, 0, 16'h0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(); ex("idle", 0, 0, 16'h0, 0, 0, 0, 0);
`ifdef MANO_INT_EN
    ifc.start = 1'b1;
    cyc(); ex("i_start", 0, 1, 16'h0, 0, 0, 0, 0);
    ifc.start = 1'b0;
    ifc.bus_in = 16'h3456;
    cyc(); ex("i_t1", 1, 1, 16'h0, 0, 0, 0, 0);
    cyc(); ex("i_load", 2, 1, 16'h3456, 0, 0, 0, 0);
    cyc(); ex("i_t3", 3, 1, 16'h3456, 0, 0, 0, 0);
    ifc.ien = 1'b1;
    ifc.fgi = 1'b1;
    cyc(); ex("i_t4", 4, 1, 16'h3456, 0, 0, 0, 0);
    ifc.ien = 1'b0;
    ifc.fgi = 1'b0;
    ifc.bus_in = 16'hFFFF;
    for (int k = 5; k < 8; k++) begin
      cyc(); ex("i_count", 3'(k), 1, 16'h3456, 0, 0, 0, 0);
    end
    cyc(); ex("int_t0", 0, 1, 16'h3456, 0, 0, 1, 1);
    ifc.sc_clr = 1'b1;
    cyc(); ex("int_t1", 1, 1, 16'h3456, 0, 0, 0, 1);
    ifc.sc_clr = 1'b0;
    cyc(); ex("int_t2", 2, 1, 16'h3456, 0, 0, 0, 1);
    cyc(); ex("int_end", 0, 1, 16'h3456, 0, 0, 0, 0);
    cyc(); ex("post_t1", 1, 1, 16'h3456, 0, 0, 0, 0);
    cyc(); ex("post_load", 2, 1, 16'hFFFF, 0, 0, 0, 0);
`endif
    repeat (3) cyc();
    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
